// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - full-search candidate scheduler with tag pipe and running-minimum SAD tracker
// Optional ME_EARLY_TERM_EN: a valid zero SAD ends issuing and drains the pipe early.
module me_search_ctrl #(
  parameter int RANGE    = 16,
  parameter int PIPE_LAT = 5,
  parameter int SAD_W    = 16,
  localparam int NCAND   = 2 * RANGE,
  localparam int CW      = $clog2(NCAND)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cand_ready,
  input  logic [SAD_W-1:0] sum_in,
  output logic             cand_valid,
  output logic [CW-1:0]    cand_x,
  output logic [CW-1:0]    cand_y,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [CW-1:0]    best_x,
  output logic [CW-1:0]    best_y
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(NCAND - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       x_cnt, y_cnt;
  logic [PIPE_LAT-1:0] tag_v;
  logic [CW-1:0]       tag_x [PIPE_LAT];
  logic [CW-1:0]       tag_y [PIPE_LAT];

  logic issue;
  logic last_cand;
  logic accept_start;
  logic cmp_valid;
  logic better;
  logic zero_hit;
  logic pending;

  assign issue        = (state == ISSUE) && cand_ready;
  assign last_cand    = (x_cnt == LAST) && (y_cnt == LAST);
  assign accept_start = (state == IDLE) && start;
  assign cmp_valid    = tag_v[PIPE_LAT-1];
  // Strict compare keeps the earlier raster candidate on ties
  assign better       = cmp_valid && (sum_in < best_sad);

`ifdef ME_EARLY_TERM_EN
  assign zero_hit = cmp_valid && (sum_in == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // Entries still ahead of the output stage; the output stage itself is compared this cycle
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      pending = pending | tag_v[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (zero_hit || (issue && last_cand)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!pending) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept_start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (issue) begin
      if (x_cnt == LAST) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Shifts every cycle: the adder tree has no stall, so bubbles travel as invalid slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_x[i] <= '0;
        tag_y[i] <= '0;
      end
    end else begin
      tag_v    <= {tag_v[PIPE_LAT-2:0], issue};
      tag_x[0] <= x_cnt;
      tag_y[0] <= y_cnt;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_x[i] <= tag_x[i-1];
        tag_y[i] <= tag_y[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad <= '0;
      best_x   <= '0;
      best_y   <= '0;
    end else if (accept_start) begin
      best_sad <= '1;
      best_x   <= '0;
      best_y   <= '0;
    end else if (better) begin
      best_sad <= sum_in;
      best_x   <= tag_x[PIPE_LAT-1];
      best_y   <= tag_y[PIPE_LAT-1];
    end
  end

  assign cand_valid = issue;
  assign cand_x     = (state == ISSUE) ? x_cnt : '0;
  assign cand_y     = (state == ISSUE) ? y_cnt : '0;
  assign busy       = (state == ISSUE) || (state == DRAIN);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_me_search_ctrl.sv
// tb/tb_me_search_ctrl.sv - directed bench for me_search_ctrl with a delay-line model of the SAD adder tree
module tb_me_search_ctrl;
  localparam int RANGE    = 16;
  localparam int PIPE_LAT = 5;
  localparam int SAD_W    = 16;
  localparam int N        = 2 * RANGE;
  localparam int CW       = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             cand_ready;
  logic [SAD_W-1:0] sum_in;
  logic             cand_valid;
  logic [CW-1:0]    cand_x;
  logic [CW-1:0]    cand_y;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [CW-1:0]    best_x;
  logic [CW-1:0]    best_y;

  me_search_ctrl #(.RANGE(RANGE), .PIPE_LAT(PIPE_LAT), .SAD_W(SAD_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cand_ready(cand_ready), .sum_in(sum_in),
    .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y), .busy(busy), .done(done),
    .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder-tree stand-in: candidate seen on the bus returns its SAD PIPE_LAT cycles later
  logic [PIPE_LAT-1:0] m_v = '0;
  logic [CW-1:0]       m_x [PIPE_LAT];
  logic [CW-1:0]       m_y [PIPE_LAT];
  int                  mode = 0;

  always @(posedge clk) begin
    m_v    <= {m_v[PIPE_LAT-2:0], cand_valid};
    m_x[0] <= cand_x;
    m_y[0] <= cand_y;
    for (int i = 1; i < PIPE_LAT; i++) begin
      m_x[i] <= m_x[i-1];
      m_y[i] <= m_y[i-1];
    end
  end

  function automatic logic [SAD_W-1:0] sad_of(input int m, input logic [CW-1:0] x, input logic [CW-1:0] y);
    case (m)
      0:       return (x == 5 && y == 9) ? 16'd37 : 16'd1000;
      1:       return ((x == 3 && y == 0) || (x == 7 && y == 4)) ? 16'd200 : 16'd500;
      2:       return (x == 2 && y == 0) ? 16'd0 : 16'd300;
      default: return (x == 31 && y == 31) ? 16'd10 : ((x == 0 && y == 0) ? 16'd11 : 16'd900);
    endcase
  endfunction

  // Bubble slots carry 0 so a bubble wrongly compared would steal the minimum
  always_comb sum_in = m_v[PIPE_LAT-1] ? sad_of(mode, m_x[PIPE_LAT-1], m_y[PIPE_LAT-1]) : '0;

  int            issue_cnt, order_err, done_cnt, first_issue_cyc, done_cyc;
  logic [CW-1:0] ex, ey;

  always @(negedge clk) begin
    if (cand_valid === 1'b1) begin
      if (issue_cnt == 0) first_issue_cyc = cyc;
      if (cand_x !== ex || cand_y !== ey) order_err++;
      issue_cnt++;
      if (ex == CW'(N - 1)) begin
        ex = '0;
        ey = ey + 1'b1;
      end else begin
        ex = ex + 1'b1;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int start_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_mon();
    issue_cnt = 0; order_err = 0; done_cnt = 0;
    first_issue_cyc = -1; done_cyc = -1;
    ex = '0; ey = '0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start_cyc = cyc + 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_best(input string tag, input int s, input int x, input int y);
    chk({tag, "_best_sad"}, 32'(best_sad), s);
    chk({tag, "_best_x"}, 32'(best_x), x);
    chk({tag, "_best_y"}, 32'(best_y), y);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cand_ready = 1'b1; mode = 0;
    reset_mon();
    #1;
    chk("rst_cand_valid", 32'(cand_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cand_x", 32'(cand_x), 0);
    chk_best("rst", 0, 0, 0);
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single minimum, no bubbles: latency and raster order
    mode = 0; reset_mon();
    do_start();
    chk("t1_busy_first", 32'(busy), 1);
    chk("t1_valid_first", 32'(cand_valid), 1);
    wait_done("t1", 1200);
    chk("t1_issues", issue_cnt, 1024);
    chk("t1_order", order_err, 0);
    chk("t1_first_issue", first_issue_cyc, start_cyc);
    chk("t1_done_cyc", done_cyc, start_cyc + 1029);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_busy_after", 32'(busy), 0);
    chk_best("t1", 37, 5, 9);

    // Tie keeps the earlier vector; start ignored while busy and in DONE
    mode = 1; reset_mon();
    do_start();
    repeat (100) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (cyc < start_cyc + 1029) begin
      @(posedge clk); #1;
    end
    chk("t2_done_now", 32'(done), 1);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t2_issues", issue_cnt, 1024);
    chk("t2_done_pulses", done_cnt, 1);
    chk("t2_done_cyc", done_cyc, start_cyc + 1029);
    chk("t2_busy_after", 32'(busy), 0);
    chk_best("t2", 200, 3, 0);

    // Alternating ready: bubbles in every other slot, minimum on the last candidate
    mode = 3; reset_mon();
    cand_ready = 1'b1;
    do_start();
    for (int k = 0; k < 2300 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      cand_ready = ~cand_ready;
    end
    cand_ready = 1'b1;
    chk("t3_done_seen", 32'(done_cnt != 0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_issues", issue_cnt, 1024);
    chk("t3_order", order_err, 0);
    chk("t3_done_cyc", done_cyc, start_cyc + 2052);
    chk_best("t3", 10, 31, 31);

    // Asynchronous abort mid-search, then a clean rerun
    mode = 0; reset_mon();
    do_start();
    while (cyc < start_cyc + 399) begin
      @(posedge clk); #1;
    end
    #2; rst_n = 1'b0;
    #1;
    chk("t4_rst_cand_valid", 32'(cand_valid), 0);
    chk("t4_rst_cand_x", 32'(cand_x), 0);
    chk("t4_rst_cand_y", 32'(cand_y), 0);
    chk("t4_rst_busy", 32'(busy), 0);
    chk_best("t4_rst", 0, 0, 0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("t4_no_done", done_cnt, 0);
    reset_mon();
    do_start();
    wait_done("t4", 1200);
    chk("t4_issues", issue_cnt, 1024);
    chk("t4_order", order_err, 0);
    chk("t4_done_cyc", done_cyc, start_cyc + 1029);
    chk_best("t4", 37, 5, 9);

    // Zero SAD early in the window
    mode = 2; reset_mon();
    do_start();
    wait_done("t5", 1200);
    chk("t5_order", order_err, 0);
`ifdef ME_EARLY_TERM_EN
    chk("t5_issues", issue_cnt, 8);
    chk("t5_done_cyc", done_cyc, start_cyc + 13);
`else
    chk("t5_issues", issue_cnt, 1024);
    chk("t5_done_cyc", done_cyc, start_cyc + 1029);
`endif
    chk_best("t5", 0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/me_search_ctrl.md
Name: me_search_ctrl

Overview:
- Full-search scheduler for the pipelined 256-pixel SAD adder tree.
- Walks every candidate displacement of the search window in raster order and issues one candidate per cycle to the reference/AD front end.
- Carries a tag for each issued candidate alongside the adder pipeline, so each returned SAD is matched to its vector.
- Keeps the running minimum SAD and its vector, and reports completion to the frame-level controller.

Parameters:
- RANGE, 16: candidates per axis = 2*RANGE; index width CW = $clog2(2*RANGE).
- PIPE_LAT, 5: cycles from cand_valid/cand_x/cand_y to the matching SAD on sum_in (AD input register plus 4 adder stages).
- SAD_W, 16: width of sum_in and best_sad.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin a search for the current block; sampled only in IDLE.
- cand_ready, in, 1: front end can accept a candidate this cycle; low inserts a bubble.
- sum_in, in, SAD_W: SAD from the adder tree.
- cand_valid, out, 1: candidate issued this cycle.
- cand_x, out, CW: horizontal candidate index.
- cand_y, out, CW: vertical candidate index.
- busy, out, 1: search in progress.
- done, out, 1: one-cycle completion pulse.
- best_sad, out, SAD_W: minimum SAD found.
- best_x, out, CW: horizontal index of the minimum.
- best_y, out, CW: vertical index of the minimum.

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; tag pipe is cleared. Reset asserted mid-search aborts immediately, with no done pulse.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 moves to ISSUE. On the same edge: best_sad <= all ones, best_x/y <= 0, x/y counters <= 0.
  - ISSUE: cand_valid = cand_ready. Outputs are combinational from state and the registered counters.
    - When cand_valid=1, x increments. When x wraps from 2*RANGE-1 to 0, y increments.
    - Issuing x=y=2*RANGE-1 moves the FSM to DRAIN.
    - When cand_ready=0, counters hold and cand_valid=0.
  - DRAIN: no issue. Leaves for DONE once the tag pipe holds no valid entries, meaning the last result has been compared.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy = 1 in ISSUE and DRAIN, 0 in IDLE and DONE.
- Tag pipe: a PIPE_LAT-deep shift register of {valid, x, y}. It shifts every cycle, including bubbles, because the adder tree has no enable.
- Compare: when the tag-pipe output is valid and sum_in < best_sad (strict), update best_sad, best_x and best_y from the tag.
  - Ties keep the earlier candidate in raster order.
  - Invalid (bubble) slots never update the best registers.
- Latency with no bubbles: start sampled at edge N.
  - cand_valid is high for cycles N+1 .. N+(2*RANGE)^2.
  - done is in cycle N+(2*RANGE)^2+PIPE_LAT+1.
  - Default parameters: 1024 issue cycles, done at N+1030.
- Output hold: best_* are stable from done until the next accepted start. start is ignored while not in IDLE, including during the DONE cycle.
- sum_in is consumed unsigned; no saturation is needed because SAD_W covers 256*255.

Optional Feature:
- Macro: ME_EARLY_TERM_EN.
- Defined: a valid compare with sum_in == 0 stops issuing from the next cycle.
  - The FSM goes to DRAIN.
  - Remaining in-flight tags still shift but cannot win a tie.
  - done then follows as normal, with best_sad = 0.
- Not defined: the full window is always searched, and zero SADs are treated like any other value.

Test Plan:
- Default params, cand_ready=1, sum_in = 1000 except 37 for tag (x=5, y=9) -> 1024 valid issues in raster order; done at N+1030; best_sad=37, best_x=5, best_y=9.
- sum_in = 200 for both (3,0) and (7,4), with all others 500 -> best stays (3,0); the tie does not update.
- cand_ready toggles 1,0 every cycle -> 1024 issues with no skipped or duplicated vector; done at N+2048+6 (±1 per the toggle phase); best vector correct.
- start pulsed again while busy and during DONE -> ignored; exactly one done pulse; results unchanged.
- rst_n low at cycle N+400 -> all outputs 0 asynchronously; no done pulse; a new start gives a clean full search.
- ME_EARLY_TERM_EN defined, sum_in=0 at tag (2,0) -> issuing stops about PIPE_LAT+1 candidates later; done follows after the drain; best_sad=0, best_x=2, best_y=0. With the macro undefined, the same stimulus searches all 1024 candidates.
